// File: rtl/max7219_serial_driver.sv
// Serialising driver for a chain of cascaded MAX7219 devices: shifts one
// 16-bit word per device out MSB first on clk/din, then strobes load.
module max7219_serial_driver #(
  parameter int G_NB_MATRIX   = 4,
  parameter int G_HALF_PERIOD = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [16*G_NB_MATRIX-1:0] i_data,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int FW = 16 * G_NB_MATRIX;
  localparam int HW = $clog2(G_HALF_PERIOD + 1);
  localparam int BW = $clog2(FW);
  localparam logic [HW-1:0] HLAST = HW'(G_HALF_PERIOD - 1);
  localparam logic [BW-1:0] BLAST = BW'(FW - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIT_LOW  = 3'd1,
    BIT_HIGH = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state_r, state_next_s;
  logic [FW-1:0] shift_r, shift_next_s;
  logic [BW-1:0] bcnt_r, bcnt_next_s;
  logic [HW-1:0] hcnt_r, hcnt_next_s;
  logic          din_next_s;
  logic          hlast_s;

  // State, datapath and output registers; outputs are decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      shift_r        <= '0;
      bcnt_r         <= '0;
      hcnt_r         <= '0;
      o_max7219_clk  <= 1'b0;
      o_max7219_din  <= 1'b0;
      o_max7219_load <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      shift_r        <= shift_next_s;
      bcnt_r         <= bcnt_next_s;
      hcnt_r         <= hcnt_next_s;
      o_max7219_clk  <= (state_next_s == BIT_HIGH);
      o_max7219_din  <= din_next_s;
      o_max7219_load <= (state_next_s == LOAD);
      o_busy         <= (state_next_s == BIT_LOW) || (state_next_s == BIT_HIGH) ||
                        (state_next_s == LOAD);
      o_done         <= (state_next_s == DONE);
    end
  end

  assign hlast_s = (hcnt_r == HLAST);

  // Next-state and datapath logic
  always_comb begin
    state_next_s = state_r;
    shift_next_s = shift_r;
    bcnt_next_s  = bcnt_r;
    hcnt_next_s  = hcnt_r;
    din_next_s   = o_max7219_din;
    case (state_r)
      IDLE: begin
        hcnt_next_s = '0;
        if (i_start) begin
          shift_next_s = i_data;
          bcnt_next_s  = BLAST;
          din_next_s   = i_data[FW-1];
          state_next_s = BIT_LOW;
        end else begin
          din_next_s   = 1'b0;
          state_next_s = IDLE;
        end
      end
      BIT_LOW: begin
        if (hlast_s) begin
          hcnt_next_s  = '0;
          state_next_s = BIT_HIGH;
        end else begin
          hcnt_next_s  = hcnt_r + HW'(1);
        end
      end
      BIT_HIGH: begin
        if (hlast_s) begin
          hcnt_next_s = '0;
          // din only moves together with the falling clock edge
          if (bcnt_r == '0) begin
            state_next_s = LOAD;
          end else begin
            shift_next_s = shift_r << 1;
            din_next_s   = shift_r[FW-2];
            bcnt_next_s  = bcnt_r - BW'(1);
            state_next_s = BIT_LOW;
          end
        end else begin
          hcnt_next_s = hcnt_r + HW'(1);
        end
      end
      LOAD: begin
        if (hlast_s) begin
          hcnt_next_s  = '0;
          state_next_s = DONE;
        end else begin
          hcnt_next_s  = hcnt_r + HW'(1);
        end
      end
      DONE: begin
        shift_next_s = '0;
        bcnt_next_s  = '0;
        hcnt_next_s  = '0;
        din_next_s   = 1'b0;
        state_next_s = IDLE;
      end
      default: begin
        shift_next_s = '0;
        bcnt_next_s  = '0;
        hcnt_next_s  = '0;
        din_next_s   = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_max7219_serial_driver.sv
// Bench for max7219_serial_driver: a single-device instance for basic timing and
// a 4-device instance checked by a scoreboard monitor with a MAX7219 chain model.
module tb_max7219_serial_driver;

  localparam int NB = 4;
  localparam int HP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_start, a_clk, a_din, a_load, a_busy, a_done;
  logic [15:0] a_data;
  logic b_start, b_clk, b_din, b_load, b_busy, b_done;
  logic [63:0] b_data;

  int checks = 0;
  int passes = 0;
  int done_total = 0;

  typedef struct {
    logic [63:0] frame;
    int          done_cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] dev_reg [NB][16];

  max7219_serial_driver #(.G_NB_MATRIX(1), .G_HALF_PERIOD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_data(a_data),
    .o_max7219_clk(a_clk), .o_max7219_din(a_din), .o_max7219_load(a_load),
    .o_busy(a_busy), .o_done(a_done)
  );

  max7219_serial_driver #(.G_NB_MATRIX(NB), .G_HALF_PERIOD(HP)) u_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_data(b_data),
    .o_max7219_clk(b_clk), .o_max7219_din(b_din), .o_max7219_load(b_load),
    .o_busy(b_busy), .o_done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: models the device chain and scores each transfer on its o_done pulse
  initial begin : monitor
    logic [63:0] chain;
    int cyc, edges, ld_cnt, ld_first, rise_ld;
    bit tracking;
    logic p_clk, p_load, p_busy;
    exp_t e;
    chain = '0; cyc = 0; edges = 0; ld_cnt = 0; ld_first = 0; rise_ld = 0;
    tracking = 1'b0; p_clk = 1'b0; p_load = 1'b0; p_busy = 1'b0;
    for (int k = 0; k < NB; k++) for (int r = 0; r < 16; r++) dev_reg[k][r] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tracking = 1'b0; p_clk = 1'b0; p_load = 1'b0; p_busy = 1'b0;
      end else begin
        if (b_busy && !p_busy) begin
          cyc = 1; edges = 0; ld_cnt = 0; ld_first = 0; rise_ld = 0; tracking = 1'b1;
        end else if (tracking) begin
          cyc++;
        end
        if (b_clk && !p_clk) begin
          edges++;
          chain = {chain[62:0], b_din};
          if (b_load) rise_ld++;
        end
        if (b_load) begin
          ld_cnt++;
          if (ld_first == 0) ld_first = cyc;
        end
        if (p_load && !b_load)
          for (int k = 0; k < NB; k++) dev_reg[k][chain[16*k+8 +: 4]] = chain[16*k +: 8];
        if (b_done) begin
          done_total++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: o_done at cycle %0d, no transfer expected", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("clk_rising_edges", edges, 64);
            check("load_high_cycles", ld_cnt, HP);
            check("load_first_cycle", ld_first, 257);
            check("rise_during_load", rise_ld, 0);
            check("shifted_frame", chain, e.frame);
          end
          tracking = 1'b0;
        end
        p_clk = b_clk; p_load = b_load; p_busy = b_busy;
      end
    end
  end

  task automatic send_b(input logic [63:0] f, input bit push);
    exp_t e;
    b_start = 1'b1;
    b_data  = f;
    if (push) begin
      e.frame = f;
      e.done_cyc = 259;
      exp_q.push_back(e);
    end
    @(negedge clk);
    b_start = 1'b0;
    b_data  = ~f;
  endtask

  // Returns on the negedge just after the o_done cycle
  task automatic wait_done(input string name);
    int n = 0;
    while (!b_done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) begin
      checks++;
      $display("FAIL %s: no o_done within %0d cycles", name, n);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] bits;
    int rises, ldc, ldf, donec, dcount, n;
    logic pc, pl;
    logic [7:0] a_reg [16];
    bits = '0; rises = 0; ldc = 0; ldf = 0; donec = 0; dcount = 0; pc = 1'b0; pl = 1'b0;
    for (int r = 0; r < 16; r++) a_reg[r] = 8'h00;
    rst_n = 1'b0; a_start = 1'b0; a_data = '0; b_start = 1'b0; b_data = '0;

    repeat (3) @(negedge clk);
    check("reset_a_outputs", {a_clk, a_din, a_load, a_busy, a_done}, 64'd0);
    check("reset_b_outputs", {b_clk, b_din, b_load, b_busy, b_done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_b_outputs", {b_clk, b_din, b_load, b_busy, b_done}, 64'd0);

    // Single device, half period 1
    a_start = 1'b1; a_data = 16'h0C01;
    @(negedge clk);
    a_start = 1'b0; a_data = 16'hFFFF;
    for (int c = 1; c <= 40; c++) begin
      if (a_clk && !pc) begin
        rises++;
        bits = {bits[14:0], a_din};
      end
      if (a_load) begin
        ldc++;
        if (ldf == 0) ldf = c;
      end
      if (pl && !a_load) a_reg[bits[11:8]] = bits[7:0];
      if (a_done) begin
        dcount++;
        if (donec == 0) donec = c;
      end
      pc = a_clk; pl = a_load;
      @(negedge clk);
    end
    check("a_bits", bits, 64'h0C01);
    check("a_rises", rises, 16);
    check("a_load_cycles", ldc, 1);
    check("a_load_first", ldf, 33);
    check("a_done_cycle", donec, 34);
    check("a_done_count", dcount, 1);
    check("a_reg_shutdown", a_reg[12], 8'h01);

    // Broadcast intensity
    send_b({4{16'h0A05}}, 1'b1);
    wait_done("broadcast");
    for (int k = 0; k < NB; k++) check("intensity", dev_reg[k][10], 8'h05);

    // Per-device digit 0
    send_b({16'h0111, 16'h0122, 16'h0133, 16'h0144}, 1'b1);
    wait_done("per_device");
    check("digit0_dev3", dev_reg[3][1], 8'h11);
    check("digit0_dev2", dev_reg[2][1], 8'h22);
    check("digit0_dev1", dev_reg[1][1], 8'h33);
    check("digit0_dev0", dev_reg[0][1], 8'h44);

    // Start while busy is ignored
    send_b({4{16'h0C01}}, 1'b1);
    repeat (8) @(negedge clk);
    b_start = 1'b1; b_data = {4{16'h0C00}};
    @(negedge clk);
    b_start = 1'b0;
    wait_done("busy_start");
    repeat (300) @(negedge clk);
    check("busy_done_total", done_total, 3);
    check("busy_shutdown", {dev_reg[3][12], dev_reg[2][12], dev_reg[1][12], dev_reg[0][12]},
          64'h01010101);

    // Back-to-back with i_start held high
    b_start = 1'b1; b_data = {4{16'h0A03}};
    exp_q.push_back('{frame: {4{16'h0A03}}, done_cyc: 259});
    exp_q.push_back('{frame: {4{16'h0A07}}, done_cyc: 259});
    @(negedge clk);
    b_data = {4{16'h0A07}};
    n = 0;
    while (!b_done && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", b_done, 1'b1);
    @(negedge clk);
    check("b2b_idle_gap", {b_busy, b_load, b_clk}, 64'd0);
    @(negedge clk);
    check("b2b_second_busy", b_busy, 1'b1);
    b_start = 1'b0;
    wait_done("b2b_second");
    check("b2b_intensity", {dev_reg[3][10], dev_reg[2][10], dev_reg[1][10], dev_reg[0][10]},
          64'h07070707);
    check("b2b_done_total", done_total, 5);

    // Reset in the middle of a frame
    send_b({4{16'h0A0F}}, 1'b0);
    repeat (39) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", {b_clk, b_din, b_load, b_busy, b_done}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_regs_kept", {dev_reg[3][10], dev_reg[2][10], dev_reg[1][10], dev_reg[0][10]},
          64'h07070707);
    check("abort_no_done", done_total, 5);
    send_b({4{16'h0A09}}, 1'b1);
    wait_done("after_abort");
    check("after_abort_regs", {dev_reg[3][10], dev_reg[2][10], dev_reg[1][10], dev_reg[0][10]},
          64'h09090909);
    check("after_abort_done_total", done_total, 6);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
